// File: rtl/decoder_nto2n_seq_if.sv
// Request/response bundle for decoder_nto2n_seq: request strobe, start index,
// mode and burst length in; one-hot write enable, busy and done out.
interface decoder_nto2n_seq_if #(
    parameter int N = 3
);
    localparam int W = 1 << N;

    logic         i_en;
    logic [N-1:0] i_sel;
    logic         i_burst;
    logic [N:0]   i_len;
    logic [W-1:0] o_out;
    logic         o_busy;
    logic         o_done;

    modport master (
        output i_en, i_sel, i_burst, i_len,
        input  o_out, o_busy, o_done
    );

    modport slave (
        input  i_en, i_sel, i_burst, i_len,
        output o_out, o_busy, o_done
    );
endinterface

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot write-enable decoder with single-shot and wrapping burst modes.
// Optional DECODER_ZERO_REG_EN: top output bit (zero register) is never asserted.
//
// state | meaning
// IDLE  | accepts a request; emits a single beat or the first beat of a burst
// BURST | walks idx+1 each cycle until rem hits zero; inputs ignored
module decoder_nto2n_seq #(
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                reset,
    decoder_nto2n_seq_if.slave  bus
);
    localparam int W = 1 << N;
    localparam logic [N:0]   LEN_ONE = (N+1)'(1);
    localparam logic [N-1:0] IDX_ONE = N'(1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t       r_state, w_state_nx;
    logic [N-1:0] r_idx, w_idx_nx;
    logic [N:0]   r_rem, w_rem_nx;
    logic [W-1:0] r_out, w_out_nx;
    logic         r_done, w_done_nx;

    function automatic logic [W-1:0] f_decode(input logic [N-1:0] idx);
        logic [W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
`ifdef DECODER_ZERO_REG_EN
        // Beat still consumes its slot; only the enable is suppressed.
        v[W-1] = 1'b0;
`else
`endif
        return v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_rem   <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_rem   <= w_rem_nx;
            r_out   <= w_out_nx;
            r_done  <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_rem_nx   = r_rem;
        w_out_nx   = '0;
        w_done_nx  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_en) begin
                    if (!bus.i_burst) begin
                        w_out_nx  = f_decode(bus.i_sel);
                        w_done_nx = 1'b1;
                    end else if (bus.i_len != '0) begin
                        w_out_nx = f_decode(bus.i_sel);
                        w_idx_nx = bus.i_sel;
                        w_rem_nx = bus.i_len - LEN_ONE;
                        if (bus.i_len == LEN_ONE)
                            w_done_nx = 1'b1;
                        else
                            w_state_nx = BURST;
                    end
                end
            end
            BURST: begin
                // idx is N bits wide, so the increment wraps modulo 2^N for free.
                w_idx_nx = r_idx + IDX_ONE;
                w_out_nx = f_decode(w_idx_nx);
                w_rem_nx = r_rem - LEN_ONE;
                if (r_rem == LEN_ONE) begin
                    w_done_nx  = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign bus.o_out  = r_out;
    assign bus.o_done = r_done;
    assign bus.o_busy = (r_state == BURST);
endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Bench for decoder_nto2n_seq: directed scenarios plus random traffic against a
// beat-queue reference model.
module tb_decoder_nto2n_seq;
    localparam int N = 3;
    localparam int W = 1 << N;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decoder_nto2n_seq_if #(.N(N)) bus ();

    decoder_nto2n_seq #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] out;
        logic         done;
        logic         busy;
    } beat_t;

    beat_t q[$];
    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic beat_t mk_beat(input int idx, input logic d, input logic b);
        beat_t r;
        r.out  = '0;
        r.out[idx] = 1'b1;
`ifdef DECODER_ZERO_REG_EN
        if (idx == W - 1) r.out = '0;
`endif
        r.done = d;
        r.busy = b;
        return r;
    endfunction

    // Drive one request, let one edge pass, update the model and compare.
    task automatic cycle(input logic en, input int sel, input logic burst, input int len);
        beat_t e;
        bus.i_en    = en;
        bus.i_sel   = N'(sel);
        bus.i_burst = burst;
        bus.i_len   = (N+1)'(len);
        @(posedge clk);
        if (q.size() == 0 && en) begin
            if (!burst)
                q.push_back(mk_beat(sel, 1'b1, 1'b0));
            else
                for (int j = 0; j < len; j++)
                    q.push_back(mk_beat((sel + j) % W, j == len - 1, j < len - 1));
        end
        if (q.size() > 0) e = q.pop_front();
        else e = '{out: '0, done: 1'b0, busy: 1'b0};
        #1;
        check_val("out",    32'(bus.o_out),  32'(e.out));
        check_val("done",   32'(bus.o_done), 32'(e.done));
        check_val("busy",   32'(bus.o_busy), 32'(e.busy));
        check_val("onehot", 32'($onehot0(bus.o_out)), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 0);
    endtask

    initial begin
        reset       = 1'b1;
        bus.i_en    = 1'b0;
        bus.i_sel   = '0;
        bus.i_burst = 1'b0;
        bus.i_len   = '0;
        #12;
        check_val("rst_out",  32'(bus.o_out),  32'd0);
        check_val("rst_busy", 32'(bus.o_busy), 32'd0);
        check_val("rst_done", 32'(bus.o_done), 32'd0);
        reset = 1'b0;

        cycle(1'b1, 5, 1'b0, 0);
        check_val("plan_sel5", 32'(bus.o_out), 32'h20);
        idle(1);

        cycle(1'b1, 6, 1'b1, 4);
        idle(5);

        cycle(1'b1, 3, 1'b1, 0);
        idle(1);
        cycle(1'b1, 0, 1'b1, 8);
        idle(8);

        cycle(1'b1, 0, 1'b1, 5);
        cycle(1'b1, 3, 1'b0, 0);
        idle(5);

        cycle(1'b1, 7, 1'b1, 1);
        cycle(1'b1, 7, 1'b0, 0);
        cycle(1'b1, 2, 1'b1, 3);
        cycle(1'b0, 0, 1'b0, 0);
        cycle(1'b1, 5, 1'b1, 2);
        cycle(1'b1, 1, 1'b1, 2);
        idle(3);

        cycle(1'b1, 6, 1'b1, 3);
        idle(3);

        // Asynchronous reset in the middle of a burst.
        cycle(1'b1, 0, 1'b1, 5);
        cycle(1'b0, 0, 1'b0, 0);
        #2 reset = 1'b1;
        #1;
        check_val("arst_out",  32'(bus.o_out),  32'd0);
        check_val("arst_busy", 32'(bus.o_busy), 32'd0);
        check_val("arst_done", 32'(bus.o_done), 32'd0);
        q.delete();
        #2 reset = 1'b0;
        cycle(1'b1, 2, 1'b0, 0);
        check_val("post_rst_sel2", 32'(bus.o_out), 32'h04);
        idle(1);

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 2) != 0, int'($urandom_range(0, W - 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, W)));
        idle(W + 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/decoder_nto2n_seq.md
# decoder_nto2n_seq

Parametrised, registered N-to-2^N one-hot decoder for register-file write enables. It generalises the 3-to-8 enable decoder with a single-shot mode and a sequential burst mode. Burst mode walks consecutive indices with wrap-around, for register-file clear and initialisation sequences. It sits between the control unit and the register-file write-enable inputs.

## Interface
- N, default 3: select width; output width 2^N; legal 1..5.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  request strobe; sampled only in IDLE.
- sel  input  N  start index (single mode: the only index).
- burst  input  1  0 = single mode, 1 = burst mode; sampled with en.
- len  input  N+1  burst beat count, 0..2^N; ignored in single mode.
- out  output  2^N  registered one-hot (or all-zero) write enable.
- busy  output  1  high while a burst occupies the block.
- done  output  1  one-cycle pulse marking the final beat of any accepted request.

## Operation
- State machine states: IDLE, BURST. Internal registers: idx (N bits), rem (N+1 bits).
- IDLE, en=1, burst=0: next cycle out = 1<<sel and done=1 for exactly one cycle. State stays IDLE.
- IDLE, en=1, burst=1, len=0: request ignored. No out, no busy, no done.
- IDLE, en=1, burst=1, len>=1: next cycle out = 1<<sel, idx=sel, rem=len-1.
  - If len=1, done=1 on that beat and state stays IDLE.
  - Otherwise state goes to BURST and busy=1.
- BURST, each cycle: idx = (idx+1) mod 2^N, out = 1<<idx, rem decrements.
  - The beat with rem=0 asserts done. The following cycle returns to IDLE with out=0 and busy=0.
- BURST ignores en, sel, burst and len entirely. There is no queueing; a request during BURST is dropped.
- Wrap-around: sel=2^N-1 followed by the next beat gives index 0.
- len=2^N visits every index exactly once.
- IDLE with en=0: out=0, done=0.
- out is at most one-hot in every cycle.

## Timing
- Latency: request sampled at edge k; out is valid after edge k+1.
- A burst of L beats occupies edges k+1..k+L. busy is high from edge k+1 through the beat before IDLE, and low on the final beat's following cycle.
- A new request is accepted in the cycle after the final beat, so back-to-back bursts have no gap beat.
- Single-mode requests are accepted every cycle: out follows sel with 1-cycle latency.
- Reset asserted (any time, including mid-burst) forces out=0, busy=0, done=0, idx=0, rem=0 and state IDLE immediately, without waiting for clk.
- After reset deasserts, the first request is accepted at the next clk edge.

## Configuration
- DECODER_ZERO_REG_EN defined:
  - out[2^N-1] is hard-wired to 0 (zero register is never written).
  - A beat targeting that index still consumes its cycle and counts toward len; out is all-zero on that beat.
  - done and busy timing are unchanged.
- DECODER_ZERO_REG_EN undefined: all 2^N outputs are decodable.

## Test plan
- Reset, then single mode N=3, sel=5 -> next cycle out=8'b0010_0000, done=1, busy=0. Following cycle with en=0 gives out=0.
- Burst sel=6, len=4 -> out sequence 0x40, 0x80, 0x01, 0x02 on four consecutive cycles. done is on the 0x02 beat; busy is high for the first three beats; then out=0.
- Burst len=0 -> no output change, no busy, no done. Burst len=8, sel=0 -> 0x01..0x80 with each bit exactly once and done on 0x80.
- During a burst sel=0, len=5, pulse en with sel=3, burst=0 on beat 2 -> request ignored. Sequence 0x01..0x10 is unaltered.
- Assert reset asynchronously mid-burst (between edges) -> out, busy and done drop to 0 before the next edge. After release, a single sel=2 request gives out=0x04.
- With DECODER_ZERO_REG_EN, burst sel=6, len=3 -> 0x40, 0x00, 0x01, with done on 0x01. Single sel=7 -> out=0x00 with done=1.
